border_frame_sequencer: RTL and testbench
=========================================

// Module: border_frame_sequencer
// PURPOSE
//  Frame-level controller for the border-detection kernel. Accepts a raster pixel stream and
//  writes each row into one of three rotating line-buffer banks. Once three rows are resident,
//  it drives the bank selects that form the kernel's top/mid/bottom rows (in1/in2/in3), pulses
//  kern_start and waits for kern_done. Emits one kernel run per interior row. Replaces
//  testbench-driven row shifting in synthesized designs.
// PARAMETERS
//  WIDTH   320  pixels per row
//  HEIGHT  240  rows per frame (>=3)
//  CW      $clog2(WIDTH)   column counter width
//  RW      $clog2(HEIGHT)  row counter width
// PORTS
//  clk         in   1   clock, all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   begin a frame; sampled only in IDLE
//  in_valid    in   1   pixel stream valid
//  in_ready    out  1   pixel stream ready
//  in_pixel    in   8   pixel, raster order (row-major, col 0 first)
//  wr_en       out  1   line-buffer write strobe
//  wr_bank     out  2   bank written (0..2)
//  wr_addr     out  CW  column written
//  wr_data     out  8   pixel written
//  top_bank    out  2   bank feeding kernel in1 (row r-2)
//  mid_bank    out  2   bank feeding kernel in2 (row r-1)
//  bot_bank    out  2   bank feeding kernel in3 (row r)
//  kern_start  out  1   one-cycle pulse: window valid, run kernel
//  kern_done   in   1   kernel finished the current window
//  out_row     out  RW  centre row index (r-1) of current/last window
//  busy        out  1   high outside IDLE
//  frame_done  out  1   one-cycle pulse after last kern_done
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters row=col=0; bank ptr=0.
//  States: IDLE -> LOAD on start. LOAD -> KICK after last column of row r when r>=2.
//  LOAD -> LOAD for the next row when r<2. KICK -> WAIT (1 cycle). WAIT -> LOAD on kern_done
//  if r<HEIGHT-1. WAIT -> DONE if r==HEIGHT-1. DONE -> IDLE (1 cycle).
//  in_ready=1 only in LOAD. Beat = in_valid&&in_ready. No beat -> counters hold.
//  Write path registered: wr_en/wr_bank/wr_addr/wr_data appear the cycle after the beat.
//  wr_bank=row mod 3, wr_addr=col.
//  col wraps WIDTH-1 -> 0 and increments row. Bank ptr wraps 2 -> 0; no modulo divider.
//  Last beat of row r (r>=2): LOAD->KICK. kern_start=1 in KICK, which coincides with that row's
//  final wr_en. The kernel samples the banks from the following cycle on.
//  Window selects are registered in KICK and held through WAIT:
//  top=(r-2)mod3, mid=(r-1)mod3, bot=r mod3, out_row=r-1.
//  Run count per frame = HEIGHT-2; out_row runs 1..HEIGHT-2.
//  kern_done outside WAIT is ignored. kern_done in the same cycle as kern_start is ignored.
//  start while busy is ignored. in_valid outside LOAD is not accepted (in_ready=0).
//  frame_done=1 in DONE only. busy=0 in IDLE only.
//  rst mid-frame: next cycle is IDLE with all outputs 0; a partial frame is discarded.
// TESTING  (WIDTH=4, HEIGHT=5 unless noted)
//  Reset mid-LOAD (row 1, col 2) -> next cycle IDLE; in_ready=0; wr_en=0; restart loads row 0 to bank 0.
//  Full frame, in_valid=1 always, kern_done 3 cycles after kern_start -> 3 kern_start pulses.
//  Those pulses give out_row=1,2,3 with (top,mid,bot)=(0,1,2),(1,2,0),(2,0,1).
//  Same frame -> frame_done pulses once; busy=0 on the following cycle.
//  in_valid toggling 1/0 -> wr_addr sequence 0,1,2,3 per row, no skips; in_ready=0 throughout WAIT.
//  kern_done held high continuously -> each WAIT lasts 1 cycle. Spurious kern_done in LOAD has no effect.
//  start asserted during WAIT -> ignored; no second frame begins after frame_done.
//  HEIGHT=240, WIDTH=320 -> 238 kern_start pulses; final out_row=238; 76800 wr_en beats.

Source files
------------

// File: rtl/border_frame_sequencer_if.sv
// Pixel-stream, line-buffer write and kernel-window signals of the border frame sequencer.
// The sequencer sits on the slave modport; its surroundings sit on the master modport.
interface border_frame_sequencer_if #(
    parameter int CW = 9,
    parameter int RW = 8
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          wr_en;
    logic [1:0]    wr_bank;
    logic [CW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [1:0]    top_bank;
    logic [1:0]    mid_bank;
    logic [1:0]    bot_bank;
    logic          kern_start;
    logic          kern_done;
    logic [RW-1:0] out_row;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, in_valid, in_pixel, kern_done,
        input  in_ready, wr_en, wr_bank, wr_addr, wr_data,
        input  top_bank, mid_bank, bot_bank, kern_start, out_row, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_pixel, kern_done,
        output in_ready, wr_en, wr_bank, wr_addr, wr_data,
        output top_bank, mid_bank, bot_bank, kern_start, out_row, busy, frame_done
    );
endinterface

// File: rtl/border_frame_sequencer.sv
// Streams raster rows into three rotating line-buffer banks and launches one kernel run
// per interior row once three rows are resident.
module border_frame_sequencer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                    clk,
    input  logic                    rst,
    border_frame_sequencer_if.slave io
);
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    bank;
    logic [1:0]    bank_next;
    logic [1:0]    bank_prev;
    logic          in_ready;
    logic          kern_start;
    logic          busy;
    logic          frame_done;
    logic          beat;
    logic          row_end;
    logic          last_row;
    logic          window_ready;

    assign beat         = io.in_valid && in_ready;
    assign row_end      = (col == CW'(WIDTH - 1));
    assign last_row     = (row == RW'(HEIGHT - 1));
    assign window_ready = (row >= RW'(2));

    // Ring arithmetic on the bank pointer; bank_next also equals (r-2) mod 3.
    assign bank_next = (bank == 2'd2) ? 2'd0 : bank + 2'd1;
    assign bank_prev = (bank == 2'd0) ? 2'd2 : bank - 2'd1;

    // NOTE: sequential state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        kern_start = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (io.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (io.in_valid && row_end && window_ready) begin
                    state_next = KICK;
                end
            end
            KICK: begin
                kern_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (io.kern_done) begin
                    state_next = (io.out_row == RW'(HEIGHT - 2)) ? DONE : LOAD;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign io.in_ready   = in_ready;
    assign io.kern_start = kern_start;
    assign io.busy       = busy;
    assign io.frame_done = frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            bank        <= 2'd0;
            io.wr_en    <= 1'b0;
            io.wr_bank  <= 2'd0;
            io.wr_addr  <= '0;
            io.wr_data  <= 8'h00;
            io.top_bank <= 2'd0;
            io.mid_bank <= 2'd0;
            io.bot_bank <= 2'd0;
            io.out_row  <= '0;
        end else begin
            io.wr_en <= beat;
            if (beat) begin
                io.wr_bank <= bank;
                io.wr_addr <= col;
                io.wr_data <= io.in_pixel;
            end

            if (state == IDLE && io.start) begin
                col  <= '0;
                row  <= '0;
                bank <= 2'd0;
            end else if (beat) begin
                if (row_end) begin
                    col  <= '0;
                    row  <= last_row ? '0 : row + RW'(1);
                    bank <= bank_next;
                    // Window is captured with the row that completes it, so it is stable
                    // from kern_start through the whole wait for kern_done.
                    if (window_ready) begin
                        io.top_bank <= bank_next;
                        io.mid_bank <= bank_prev;
                        io.bot_bank <= bank;
                        io.out_row  <= row - RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_border_frame_sequencer.sv
// Self-checking bench for border_frame_sequencer: random frames on a 4x5 instance checked
// against a raster/window reference model, plus one full 320x240 frame on a second instance.
module tb_border_frame_sequencer;
    localparam int W   = 4;
    localparam int H   = 5;
    localparam int CW  = $clog2(W);
    localparam int RW  = $clog2(H);
    localparam int BW  = 320;
    localparam int BH  = 240;
    localparam int BCW = $clog2(BW);
    localparam int BRW = $clog2(BH);

    logic clk;
    logic rst;
    int   total;
    int   bad;

    border_frame_sequencer_if #(.CW(CW),  .RW(RW))  io ();
    border_frame_sequencer_if #(.CW(BCW), .RW(BRW)) io_big ();

    border_frame_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    border_frame_sequencer #(.WIDTH(BW), .HEIGHT(BH)) dut_big (
        .clk (clk),
        .rst (rst),
        .io  (io_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // vmode: 0 in_valid always high, 1 toggling, 2 random.
    // lat: >0 kern_done pulsed lat cycles after kern_start, 0 kern_done held high, <0 random 1..4.
    task automatic run_frame(input int vmode, input int lat, input bit start_in_wait,
                             input string tag);
        int         n = W * H;
        logic [7:0] pix[$];
        int         obs_w[$];
        int         obs_run[$];
        int         gaps[$];
        int         exp_gaps[$];
        int         idx = 0;
        int         cyc = 0;
        int         kick_cyc = 0;
        int         done_at = -1;
        int         cur_lat = 1;
        int         fd_count = 0;
        int         activity = 0;
        bit         waiting = 1'b0;
        bit         beat_prev = 1'b0;
        bit         fd_seen = 1'b0;
        bit         finished = 1'b0;
        bit         toggle = 1'b1;
        bit         v;

        for (int i = 0; i < n; i++) pix.push_back(8'($urandom));

        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;

        while (!finished && cyc < 600) begin
            if (beat_prev) idx++;
            if (io.wr_en) obs_w.push_back(int'({io.wr_bank, io.wr_addr, io.wr_data}));
            if (fd_seen) begin
                check({tag, " busy after frame_done"}, 32'(io.busy), 0);
                finished = 1'b1;
            end
            if (io.frame_done) begin
                if (!fd_seen) check({tag, " frame_done latency"}, cyc - done_at, 1);
                fd_count++;
                fd_seen = 1'b1;
            end
            if (io.kern_start) begin
                obs_run.push_back(int'({io.out_row, io.top_bank, io.mid_bank, io.bot_bank}));
                kick_cyc = cyc;
                cur_lat  = (lat < 0) ? int'($urandom_range(1, 4)) : lat;
                done_at  = kick_cyc + ((cur_lat == 0) ? 1 : cur_lat);
                waiting  = 1'b1;
            end else if (waiting && io.in_ready) begin
                gaps.push_back(cyc - kick_cyc);
                exp_gaps.push_back(done_at - kick_cyc + 1);
                waiting = 1'b0;
            end

            case (vmode)
                0:       v = 1'b1;
                1:       begin v = toggle; toggle = !toggle; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            io.in_valid  = v && (idx < n);
            io.in_pixel  = (idx < n) ? pix[idx] : 8'h00;
            io.kern_done = (lat == 0) ? 1'b1 : (waiting && cyc == done_at);
            io.start     = start_in_wait && waiting && !fd_seen;
            beat_prev    = io.in_valid && io.in_ready;
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        io.in_valid  = 1'b0;
        io.kern_done = 1'b0;
        io.start     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (io.busy || io.wr_en || io.kern_start) activity++;
        end

        check({tag, " frame finished"}, 32'(finished), 1);
        check({tag, " write count"}, obs_w.size(), n);
        for (int i = 0; i < n && i < obs_w.size(); i++)
            check($sformatf("%s write %0d", tag, i), obs_w[i],
                  (((i / W) % 3) << 10) | ((i % W) << 8) | int'(pix[i]));
        check({tag, " kernel runs"}, obs_run.size(), H - 2);
        for (int k = 0; k < obs_run.size() && k < H - 2; k++) begin
            int r = k + 2;
            check($sformatf("%s window %0d", tag, k), obs_run[k],
                  ((r - 1) << 6) | (((r - 2) % 3) << 4) | (((r - 1) % 3) << 2) | (r % 3));
        end
        check({tag, " resumed loads"}, gaps.size(), H - 3);
        for (int k = 0; k < gaps.size(); k++)
            check($sformatf("%s kick-to-load gap %0d", tag, k), gaps[k], exp_gaps[k]);
        check({tag, " frame_done pulses"}, fd_count, 1);
        check({tag, " idle after frame"}, activity, 0);
    endtask

    initial begin
        int  bw;
        int  bk;
        int  blast;
        bit  bfd;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        io.start = 1'b0;      io.in_valid = 1'b0;     io.in_pixel = 8'h00;     io.kern_done = 1'b0;
        io_big.start = 1'b0;  io_big.in_valid = 1'b0; io_big.in_pixel = 8'h00; io_big.kern_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",       32'(io.busy),       0);
        check("reset in_ready",   32'(io.in_ready),   0);
        check("reset wr_en",      32'(io.wr_en),      0);
        check("reset kern_start", 32'(io.kern_start), 0);
        check("reset frame_done", 32'(io.frame_done), 0);
        check("reset out_row",    32'(io.out_row),    0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(0, 3, 1'b0, "steady/lat3");
        run_frame(1, 0, 1'b0, "toggle/done-held");
        run_frame(2, -1, 1'b1, "random/start-in-wait");

        // Abort a frame after row 1 column 2 has become the next pixel to load.
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            io.in_valid = 1'b1;
            io.in_pixel = 8'($urandom);
            @(posedge clk); #1;
        end
        check("pre-reset wr_en", 32'(io.wr_en), 1);
        check("pre-reset busy",  32'(io.busy),  1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-load reset busy",     32'(io.busy),     0);
        check("mid-load reset in_ready", 32'(io.in_ready), 0);
        check("mid-load reset wr_en",    32'(io.wr_en),    0);
        check("mid-load reset out_row",  32'(io.out_row),  0);
        check("mid-load reset banks",    32'({io.top_bank, io.mid_bank, io.bot_bank}), 0);
        rst = 1'b0;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        check("post-reset idle", 32'(io.busy), 0);
        run_frame(0, 0, 1'b0, "restart");

        io_big.start = 1'b1;
        @(posedge clk); #1;
        io_big.start     = 1'b0;
        io_big.in_valid  = 1'b1;
        io_big.kern_done = 1'b1;
        bw = 0; bk = 0; blast = 0; bfd = 1'b0;
        for (int c = 0; c < 80000 && !bfd; c++) begin
            io_big.in_pixel = 8'($urandom);
            @(posedge clk); #1;
            if (io_big.wr_en) bw++;
            if (io_big.kern_start) begin
                bk++;
                blast = int'(io_big.out_row);
            end
            if (io_big.frame_done) bfd = 1'b1;
        end
        io_big.in_valid  = 1'b0;
        io_big.kern_done = 1'b0;
        check("320x240 frame_done", 32'(bfd), 1);
        check("320x240 wr_en beats", bw, BW * BH);
        check("320x240 kern_start pulses", bk, BH - 2);
        check("320x240 final out_row", blast, BH - 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
